// File: rtl/sig_delay_line.sv
// Multi-channel programmable delay line with optional minimum-pulse stretch.
// Delays each channel by 0..DEPTH clock cycles and can widen short pulses to MIN_PULSE cycles.
module sig_delay_line #(
  parameter  int WIDTH     = 4,
  parameter  int DEPTH     = 8,
  parameter  int MIN_PULSE = 3,
  localparam int SELW      = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [SELW-1:0]  dly_sel_i,
  input  logic             stretch_en_i,
  output logic [WIDTH-1:0] z_o,
  output logic             busy_o
);

  localparam int CNTW = $clog2(MIN_PULSE + 1);

  typedef logic [CNTW-1:0] cnt_t;

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  cnt_t             cnt_q   [WIDTH];
  cnt_t             cnt_d   [WIDTH];
  logic [WIDTH-1:0] raw_q;
  logic [WIDTH-1:0] raw_d;

  logic [SELW-1:0]  tapSel;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] cntNz;
  logic             stageNz;

  // Out-of-range selections saturate to the deepest tap.
  always_comb begin
    tapSel = dly_sel_i;
    if (dly_sel_i > SELW'(DEPTH)) begin
      tapSel = SELW'(DEPTH);
    end
  end

  // Tap mux: zero selects the combinational bypass, otherwise stage d-1.
  always_comb begin
    raw = a_i;
    for (int k = 0; k < DEPTH; k++) begin
      if (tapSel == SELW'(k + 1)) begin
        raw = stage_q[k];
      end
    end
  end

  always_comb begin
    stage_d[0] = a_i;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Stretch counters: a rising edge reloads, otherwise count down to zero; disabled means cleared.
  always_comb begin
    rise  = raw & ~raw_q;
    raw_d = raw;
    for (int i = 0; i < WIDTH; i++) begin
      cntNz[i] = (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i];
      if (!stretch_en_i) begin
        cnt_d[i] = '0;
      end else if (rise[i]) begin
        cnt_d[i] = cnt_t'(MIN_PULSE - 1);
      end else if (cntNz[i]) begin
        cnt_d[i] = cnt_q[i] - cnt_t'(1);
      end
    end
  end

  always_comb begin
    stageNz = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      stageNz = stageNz | (|stage_q[k]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      raw_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      raw_q <= raw_d;
    end
  end

  // Reset gates the output so the bypass path cannot leak a while rst is high.
  assign z_o    = rst_i ? '0 : (raw | ({WIDTH{stretch_en_i}} & cntNz));
  assign busy_o = stageNz | (|cntNz);

endmodule

// File: tb/tb_sig_delay_line.sv
// Directed, table-driven bench for sig_delay_line (WIDTH=4, DEPTH=8, MIN_PULSE=3).
module tb_sig_delay_line;

  localparam int WIDTH     = 4;
  localparam int DEPTH     = 8;
  localparam int MIN_PULSE = 3;
  localparam int SELW      = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [SELW-1:0]  dlySel;
  logic             stretchEn;
  logic [WIDTH-1:0] z;
  logic             busy;

  int numChecks = 0;
  int numFails  = 0;

  typedef struct {
    string      name;
    bit         flush;
    logic [3:0] a;
    logic [3:0] dly;
    logic       str;
    logic [3:0] expZ;
    logic       expBusy;
  } vec_t;

  vec_t vecs[$];

  sig_delay_line #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .MIN_PULSE(MIN_PULSE)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .a_i(a),
    .dly_sel_i(dlySel),
    .stretch_en_i(stretchEn),
    .z_o(z),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic void addVec(input string n, input bit f, input logic [3:0] av,
                                 input logic [3:0] dv, input logic sv,
                                 input logic [3:0] ez, input logic eb);
    vec_t v;
    v.name = n; v.flush = f; v.a = av; v.dly = dv; v.str = sv; v.expZ = ez; v.expBusy = eb;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] expZ, input logic expBusy);
    numChecks++;
    if (z !== expZ) begin
      numFails++;
      $display("[TB] FAIL %s: z=%h expected %h", name, z, expZ);
    end
    numChecks++;
    if (busy !== expBusy) begin
      numFails++;
      $display("[TB] FAIL %s: busy=%b expected %b", name, busy, expBusy);
    end
  endtask

  // Drives one cycle's inputs just after the rising edge.
  task automatic applyStimulus(input logic [3:0] av, input logic [3:0] dv, input logic sv);
    @(posedge clk);
    #1;
    a = av; dlySel = dv; stretchEn = sv;
  endtask

  task automatic flushLine();
    repeat (10) applyStimulus(4'h0, 4'd0, 1'b0);
    #3;
    checkOutput("flush", 4'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running, required $finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0] expR [10];

    // Single pulse on channel 0, delay 3, no stretch.
    addVec("dly3_c0", 1, 4'h1, 4'd3, 1'b0, 4'h0, 1'b0);
    for (int c = 1; c < 10; c++)
      addVec($sformatf("dly3_c%0d", c), 0, 4'h0, 4'd3, 1'b0, (c == 3) ? 4'h1 : 4'h0, (c < 9));

    // One-cycle pulse on channel 1, delay 2, stretched to three cycles.
    addVec("str1_c0", 1, 4'h2, 4'd2, 1'b1, 4'h0, 1'b0);
    for (int c = 1; c < 10; c++)
      addVec($sformatf("str1_c%0d", c), 0, 4'h0, 4'd2, 1'b1,
             (c >= 2 && c <= 4) ? 4'h2 : 4'h0, (c < 9));

    // Five-cycle pulse passes unchanged.
    for (int c = 0; c < 10; c++)
      addVec($sformatf("str5_c%0d", c), (c == 0), (c <= 4) ? 4'h2 : 4'h0, 4'd2, 1'b1,
             (c >= 2 && c <= 6) ? 4'h2 : 4'h0, (c >= 1));

    // Two pulses two cycles apart on channel 2 merge into one five-cycle run.
    for (int c = 0; c < 8; c++)
      addVec($sformatf("merge_c%0d", c), (c == 0), (c == 0 || c == 2) ? 4'h4 : 4'h0, 4'd1, 1'b1,
             (c >= 1 && c <= 5) ? 4'h4 : 4'h0, (c >= 1));

    // Selection 9 saturates to the deepest tap (8).
    addVec("sat_c0", 1, 4'h1, 4'd9, 1'b0, 4'h0, 1'b0);
    for (int c = 1; c < 10; c++)
      addVec($sformatf("sat_c%0d", c), 0, 4'h0, 4'd9, 1'b0, (c == 8) ? 4'h1 : 4'h0, (c < 9));

    // Bypass with simultaneous rises on channels 1 and 3, each stretched.
    addVec("multi_c0", 1, 4'hA, 4'd0, 1'b1, 4'hA, 1'b0);
    addVec("multi_c1", 0, 4'h0, 4'd0, 1'b1, 4'hA, 1'b1);
    addVec("multi_c2", 0, 4'h0, 4'd0, 1'b1, 4'hA, 1'b1);
    addVec("multi_c3", 0, 4'h0, 4'd0, 1'b1, 4'h0, 1'b1);

    // Dropping stretch_en truncates at once and clears the counter.
    addVec("trunc_c0", 1, 4'h1, 4'd0, 1'b1, 4'h1, 1'b0);
    addVec("trunc_c1", 0, 4'h0, 4'd0, 1'b0, 4'h0, 1'b1);
    addVec("trunc_c2", 0, 4'h0, 4'd0, 1'b1, 4'h0, 1'b1);

    // Counting stream at delay 6, then delay switched to 1.
    addVec("chg_c0", 1, 4'h1, 4'd6, 1'b0, 4'h0, 1'b0);
    addVec("chg_c1", 0, 4'h2, 4'd6, 1'b0, 4'h0, 1'b1);
    addVec("chg_c2", 0, 4'h3, 4'd6, 1'b0, 4'h0, 1'b1);
    addVec("chg_c3", 0, 4'h4, 4'd6, 1'b0, 4'h0, 1'b1);
    addVec("chg_c4", 0, 4'h5, 4'd6, 1'b0, 4'h0, 1'b1);
    addVec("chg_c5", 0, 4'h6, 4'd6, 1'b0, 4'h0, 1'b1);
    addVec("chg_c6", 0, 4'h7, 4'd6, 1'b0, 4'h1, 1'b1);
    addVec("chg_c7", 0, 4'h8, 4'd6, 1'b0, 4'h2, 1'b1);
    addVec("chg_c8", 0, 4'h9, 4'd6, 1'b0, 4'h3, 1'b1);
    addVec("chg_c9", 0, 4'hA, 4'd6, 1'b0, 4'h4, 1'b1);
    addVec("chg_c10", 0, 4'hB, 4'd1, 1'b0, 4'hA, 1'b1);
    addVec("chg_c11", 0, 4'hC, 4'd1, 1'b0, 4'hB, 1'b1);

    rst = 1'b1; a = 4'hF; dlySel = '0; stretchEn = 1'b0;
    #2;
    checkOutput("reset_hold", 4'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_after_edges", 4'h0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("release_bypass", 4'hF, 1'b0);
    @(posedge clk);
    #4;
    checkOutput("first_capture", 4'hF, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].flush) flushLine();
      applyStimulus(vecs[i].a, vecs[i].dly, vecs[i].str);
      #3;
      checkOutput(vecs[i].name, vecs[i].expZ, vecs[i].expBusy);
    end

    // Async reset while a stretch is active and the pipeline is full.
    flushLine();
    for (int c = 0; c < 10; c++)
      applyStimulus((c % 2 == 0) ? 4'hF : 4'h0, 4'd4, 1'b1);
    #3;
    checkOutput("pre_reset", 4'hF, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 4'h0, 1'b0);
    @(posedge clk);
    #3;
    checkOutput("reset_held", 4'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0; a = 4'h0; dlySel = 4'd4; stretchEn = 1'b1;
    #2;
    checkOutput("post_reset_r0", 4'h0, 1'b0);
    expR = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};
    for (int r = 1; r < 10; r++) begin
      applyStimulus((r == 2) ? 4'h2 : 4'h0, 4'd4, 1'b1);
      #3;
      checkOutput($sformatf("post_reset_r%0d", r), expR[r], (r >= 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
